wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order writeback stage and the multi-cycle mul/div unit, which returns results out of band. Mul/div results wait in a small FIFO and drain into idle write-port cycles. A starvation counter forces a one-cycle pipeline freeze when the FIFO cannot drain. The block sits between writeback, the mul/div unit and the regfile, and exports a pending-destination mask for hazard detection.

---
 rtl/wb_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The writeback stage always has priority.
// Mul/div results wait in a small FIFO and drain into idle port cycles.
// When the writeback stage keeps the port busy for too long, a one-cycle
// pipeline freeze is forced so that the oldest queued result can drain.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic                       wb_regwrite,
    input  logic [4:0]                 wb_dst,
    input  logic [63:0]                wb_data,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [4:0]                 md_dst,
    input  logic [63:0]                md_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_wa,
    output logic [63:0]                rf_wd,
    output logic                       stall_req,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and control state
    logic [DEPTH-1:0] valid_reg;
    logic [4:0]       dst_reg  [DEPTH];
    logic [63:0]      data_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [SW-1:0]    starve_reg;
    logic             stall_reg;

    // Next-state values
    logic [DEPTH-1:0] valid_next;
    logic [CW-1:0]    count_next;
    logic [SW-1:0]    starve_next;
    logic             stall_next;

    // Per-cycle decisions
    logic             pw;
    logic             occupied;
    logic             head_valid;
    logic             head_killed;
    logic             enq;
    logic             drain;
    logic             pop;
    logic             any_valid;
    logic [DEPTH-1:0] kill;

    assign occupied    = (count_reg != '0);
    assign head_valid  = occupied & valid_reg[rd_ptr_reg];
    assign head_killed = occupied & ~valid_reg[rd_ptr_reg];
    assign any_valid   = |valid_reg;

    // The pipeline write; suppressed during a freeze cycle and while in reset
    // so nothing reaches the regfile once reset is asserted.
    assign pw = wb_valid & wb_regwrite & (wb_dst != 5'd31) & ~stall_reg & ~reset;

    // Acceptance depends on registered occupancy only, never on this cycle's pop.
    assign md_ready = (count_reg < CW'(DEPTH));

    // XZR results and results overwritten by the same-cycle pipeline write
    // are accepted but never stored.
    assign enq = md_valid & md_ready & (md_dst != 5'd31) & ~(pw & (md_dst == wb_dst));

    assign drain = ~pw & head_valid & ~reset;
    assign pop   = drain | head_killed;

    assign stall_req  = stall_reg;
    assign fifo_count = count_reg;

    // A younger pipeline write to the same register supersedes queued results.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
            assign kill[gi] = pw & valid_reg[gi] & (dst_reg[gi] == wb_dst);
        end
    endgenerate

    // Write-port mux: pipeline first, then the FIFO head, else idle zeros.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 64'd0;
        if (pw) begin
            rf_we = 1'b1;
            rf_wa = wb_dst;
            rf_wd = wb_data;
        end else if (drain) begin
            rf_we = 1'b1;
            rf_wa = dst_reg[rd_ptr_reg];
            rf_wd = data_reg[rd_ptr_reg];
        end
    end

    // Hazard mask from registered entries only.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_reg[i]) begin
                pending_mask[dst_reg[i]] = 1'b1;
            end
        end
    end

    // Valid bits and occupancy: kills, head pop and enqueue all apply together.
    always_comb begin
        valid_next = valid_reg & ~kill;
        if (pop) begin
            valid_next[rd_ptr_reg] = 1'b0;
        end
        if (enq) begin
            valid_next[wr_ptr_reg] = 1'b1;
        end
        count_next = count_reg + CW'(enq) - CW'(pop);
    end

    // Starvation counter; reaching the limit launches the freeze and restarts the count.
    always_comb begin
        starve_next = starve_reg;
        stall_next  = 1'b0;
        if (drain || !any_valid) begin
            starve_next = '0;
        end else if (head_valid) begin
            if (int'(starve_reg) + 1 >= STARVE_LIMIT) begin
                stall_next  = 1'b1;
                starve_next = '0;
            end else begin
                starve_next = starve_reg + SW'(1);
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            valid_reg  <= valid_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
        end
    end

    // Payload storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (enq) begin
            dst_reg[wr_ptr_reg]  <= md_dst;
            data_reg[wr_ptr_reg] <= md_data;
        end
    end

endmodule
